// File: rtl/restoring_div64x32.sv
// Sequential radix-2 restoring divider: 64-bit unsigned dividend / 32-bit divisor,
// one quotient bit per cycle, with divide-by-zero and quotient-overflow detection.
module restoring_div64x32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic [31:0] rem_r;
  logic [31:0] q_r;
  logic [31:0] dvs_r;
  logic        pend_r;
  logic        pend_dbz_r;
  logic [31:0] pend_rem_r;

  logic [32:0] t_s;
  logic [32:0] diff_s;
  logic        ge_s;
  logic [31:0] rem_nxt_s;
  logic [31:0] q_nxt_s;

  // One restoring step: shift in the next dividend bit, subtract when it fits (33-bit compare)
  always_comb begin
    t_s    = {rem_r, q_r[31]};
    diff_s = t_s - {1'b0, dvs_r};
    ge_s   = (t_s >= {1'b0, dvs_r});
    if (ge_s) begin
      rem_nxt_s = diff_s[31:0];
    end else begin
      rem_nxt_s = t_s[31:0];
    end
    q_nxt_s = {q_r[30:0], ge_s};
  end

  // Control FSM, iteration datapath and registered result/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 5'd0;
      rem_r       <= 32'd0;
      q_r         <= 32'd0;
      dvs_r       <= 32'd0;
      pend_r      <= 1'b0;
      pend_dbz_r  <= 1'b0;
      pend_rem_r  <= 32'd0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      // Exceptions detected at accept publish their result one edge later
      if (pend_r) begin
        quotient    <= 32'hFFFF_FFFF;
        remainder   <= pend_rem_r;
        div_by_zero <= pend_dbz_r;
        overflow    <= ~pend_dbz_r;
        done        <= 1'b1;
        pend_r      <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            if (divisor == 32'd0) begin
              pend_r     <= 1'b1;
              pend_dbz_r <= 1'b1;
              pend_rem_r <= dividend[31:0];
            end else if (dividend[63:32] >= divisor) begin
              pend_r     <= 1'b1;
              pend_dbz_r <= 1'b0;
              pend_rem_r <= 32'd0;
            end else begin
              rem_r   <= dividend[63:32];
              q_r     <= dividend[31:0];
              dvs_r   <= divisor;
              cnt_r   <= 5'd0;
              busy    <= 1'b1;
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          rem_r <= rem_nxt_s;
          q_r   <= q_nxt_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            quotient    <= q_nxt_s;
            remainder   <= rem_nxt_s;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            cnt_r       <= 5'd0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cnt_r   <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div64x32.sv
// Scoreboard bench for restoring_div64x32: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_restoring_div64x32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        overflow;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_cmp;
  int   n_err;

  restoring_div64x32 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation, on time
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient",    {32'd0, quotient},    {32'd0, e.q});
        check("remainder",   {32'd0, remainder},   {32'd0, e.r});
        check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
        check("overflow",    {63'd0, overflow},    {63'd0, e.ovf});
        check("latency",     64'(cyc),             64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [63:0] dvd, input logic [31:0] dvs, input logic [31:0] eq,
                       input logic [31:0] er, input logic edbz, input logic eovf);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~dvd;
    divisor  = ~dvs;
    e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
    e.cyc = cyc + ((edbz || eovf) ? 1 : 32);
    sb.push_back(e);
    if (edbz || eovf) check("exc_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic drain(input int tail);
    for (int i = 0; i < 100 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      check("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (tail) @(negedge clk);
  endtask

  task automatic run(input logic [63:0] dvd, input logic [31:0] dvs, input logic [31:0] eq,
                     input logic [31:0] er, input logic edbz, input logic eovf);
    issue(dvd, dvs, eq, er, edbz, eovf);
    drain(2);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_q"},    {32'd0, quotient},    64'd0);
    check({tag, "_r"},    {32'd0, remainder},   64'd0);
    check({tag, "_busy"}, {63'd0, busy},        64'd0);
    check({tag, "_done"}, {63'd0, done},        64'd0);
    check({tag, "_dbz"},  {63'd0, div_by_zero}, 64'd0);
    check({tag, "_ovf"},  {63'd0, overflow},    64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    exp_t        e;
    cyc = 0; n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; dividend = 64'd0; divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors (hand-computed)
    run(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    run(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run(64'h1234_5678_9ABC_DEF0, 32'd0, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b0);
    run(64'h1_0000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    run(64'h0000_0005_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    run(64'h0000_0004_FFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd4, 1'b0, 1'b0);
    run(64'h8000_0000_0000_0000, 32'h8000_0001, 32'hFFFF_FFFE, 32'd2, 1'b0, 1'b0);
    run(64'd13, 32'hFFFF_FFFF, 32'd0, 32'd13, 1'b0, 1'b0);
    run(64'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    run(64'h0000_0000_FFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);

    // Start while busy: second request at cycle 10 must be ignored
    issue(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 64'd81; divisor = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain(40);

    // Reset mid-operation after 15 iterations
    issue(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("midrst");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    run(64'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0);

    // Back-to-back: start in the done cycle, first result held until second done
    issue(64'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #1;
    end
    check("b2b_first_done", {63'd0, done}, 64'd1);
    start = 1'b1; dividend = 64'd81; divisor = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 64'd0; divisor = 32'd0;
    e.q = 32'd9; e.r = 32'd0; e.dbz = 1'b0; e.ovf = 1'b0; e.cyc = cyc + 32;
    sb.push_back(e);
    repeat (31) @(negedge clk);
    check("b2b_held_q", {32'd0, quotient}, 64'd100);
    drain(2);

    // Multiplier round-trip: (a*b)/b == a, remainder 0
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (b == 32'd0) b = 32'd1;
      p = {32'd0, a} * {32'd0, b};
      issue(p, b, a, 32'd0, 1'b0, 1'b0);
      drain(0);
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
